rt_pixel_scan: RTL
==================

# rt_pixel_scan

Pixel coordinate sequencer directly upstream of the ray generation unit. On a start command it walks a raster of runtime-configured width × height in row-major order. Each pixel is emitted as one or more samples on a valid/ready stream. The x/y coordinates are produced as signed fixed-point values on `sfp_if` ports, which feed the RGU's `x`/`y` inputs.

## Interface
Parameters:
- `DIM_W`, default 11: width of dimension and counter fields; maximum image side is 2^DIM_W − 1.
- `SPP_W`, default 8: width of the samples-per-pixel field.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle frame start request.
- `abort`  in  1  synchronous frame cancel.
- `img_w`  in  DIM_W  image width in pixels; latched at accepted start.
- `img_h`  in  DIM_W  image height in pixels; latched at accepted start.
- `spp`  in  SPP_W  samples per pixel; latched at accepted start; 0 is treated as 1.
- `ready`  in  1  downstream accepts the current beat.
- `valid`  out  1  beat present.
- `x`  sfp_if.out  —  pixel column, fixed point; the interface's IW/QW apply.
- `y`  sfp_if.out  —  pixel row, fixed point.
- `last_row`  out  1  beat is the final sample of the final column of its row.
- `last_frame`  out  1  beat is the final beat of the frame.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- The FSM has two states, `IDLE` and `RUN`.
- `IDLE`, start accepted:
  - `start` is sampled only in `IDLE`.
  - With `img_w`≠0 and `img_h`≠0: latch dimensions and spp; clear the column counter `cx`, row counter `cy` and sample counter `cs`; go to `RUN`.
- `IDLE`, zero-size start: if `img_w` or `img_h` is 0, stay in `IDLE` and pulse `done` the next cycle. No beats are emitted.
- `RUN`:
  - `valid`=1.
  - A beat is accepted when `valid && ready`. On acceptance, increment `cs`.
  - When `cs` wraps at spp−1, increment `cx`.
  - When `cx` wraps at img_w−1, increment `cy`.
  - Acceptance of the beat with `last_frame`=1 returns the FSM to `IDLE` and pulses `done`.
- `start` while in `RUN` is ignored.
- `abort`:
  - Valid in any state; it has priority over acceptance.
  - Next cycle: `IDLE`, `valid`=0, `busy`=0, no `done` pulse.
  - This is the only case in which `valid` may fall without acceptance.
- Stability: while `valid && !ready`, the `x`, `y`, `last_row` and `last_frame` values are held constant.
- Coordinate arithmetic:
  - `x.val` = `cx` << QW, zero-extended into the signed word; `y.val` uses `cy` in the same way.
  - IW−1 ≥ DIM_W is required, so coordinates are always non-negative.
- `last_row` = (`cx`==img_w−1) && (`cs`==spp−1).
- `last_frame` = `last_row` && (`cy`==img_h−1).
- `busy` = (state==`RUN`).

## Timing
- Reset values:
  - `valid`, `busy`, `done`, `last_row`, `last_frame` = 0.
  - `x.val`, `y.val` = 0.
  - State = `IDLE`; all counters = 0; LFSR = 16'hACE1.
- Start latency: `start` at cycle N gives first `valid` at N+1.
- Throughput: 1 beat/cycle while `ready`=1. A frame is img_w·img_h·max(spp,1) beats.
- `done` is high in the cycle after final acceptance, while `busy`=0. A `start` in that same cycle is accepted.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous).

## Configuration
Macro `RT_PIXEL_SCAN_JITTER_EN` controls sub-pixel jitter for antialiasing.

Defined:
- A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seeded 16'hACE1 at reset, advances once per accepted beat.
- `x.val` = (`cx`<<QW) + {lfsr[QW−1:0]} − 2^(QW−1).
- `y.val` uses lfsr[15:16−QW] in the same way.
- The result is an offset in [−0.5, 0.5) pixel. The coordinate may be negative at column/row 0.
- QW ≤ 16 is required.

Undefined:
- No LFSR is instantiated; the fractional bits are always 0.

## Structure
- `rt_pkg` holds:
  - default constants `RT_DIM_W` and `RT_SPP_W`;
  - the LFSR seed `RT_LFSR_SEED` and the tap mask;
  - the state typedef `rt_scan_state_e` {`IDLE`, `RUN`}.
- One sub-module, `rt_lfsr16`, with inputs clk, rst_n and advance, and a 16-bit state output. It is instantiated only under the macro.

## Test plan
- Basic raster, jitter off: img_w=3, img_h=2, spp=1, `ready`=1.
  - Expect 6 beats: (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - `last_row` on beats 3 and 6; `last_frame` on beat 6.
  - `done` one cycle after beat 6; `valid` first seen one cycle after `start`.
- Backpressure: img_w=2, img_h=2; drop `ready` for 3 cycles on beat 2.
  - Expect (1,0) held stable throughout the stall; no beat lost or repeated; 4 beats total.
- Multiple samples per pixel: spp=3, img_w=2, img_h=1.
  - Expect (0,0)×3 then (1,0)×3; `last_row` only on beat 6.
  - A second run with spp=0 gives 2 beats.
- Zero size: `start` with img_w=0.
  - Expect no `valid`; `done` one cycle later; `busy` stays 0.
- Abort and restart: `abort` after beat 2 of a 4×4 frame.
  - Expect `valid`=0 and `busy`=0 next cycle, and no `done`.
  - A new `start` restarts at (0,0). A `start` issued while busy is ignored.
- Jitter (with `RT_PIXEL_SCAN_JITTER_EN`, QW=8):
  - The first beat's `x.val` equals the value computed from LFSR 16'hACE1 by a reference model.
  - Every fraction lies in [−0.5, 0.5).
  - Reset mid-frame restores the seed.

Source files
------------

// File: rtl/rt_pixel_scan_pkg.sv
// Shared constants and types for the pixel scan sequencer.
package rt_pkg;

    localparam int unsigned RT_DIM_W     = 11;
    localparam int unsigned RT_SPP_W     = 8;
    localparam logic [15:0] RT_LFSR_SEED = 16'hACE1;
    // Taps for x^16 + x^14 + x^13 + x^11 + 1 (state bits 15, 13, 12, 10).
    localparam logic [15:0] RT_LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE,
        RUN
    } rt_scan_state_e;

endpackage

// File: rtl/rt_pixel_scan_if.sv
// Signed fixed-point value carrier: IW integer bits (incl. sign), QW fraction bits.
interface sfp_if #(
    parameter int unsigned IW = 16,
    parameter int unsigned QW = 8
);

    logic signed [IW+QW-1:0] val;

    modport out (output val);
    modport in  (input  val);

endinterface

// File: rtl/rt_pixel_scan_lfsr.sv
// 16-bit Fibonacci LFSR for sub-pixel jitter; only built with RT_PIXEL_SCAN_JITTER_EN.
`ifdef RT_PIXEL_SCAN_JITTER_EN
module rt_lfsr16
    import rt_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RT_LFSR_SEED;
        end else if (advance) begin
            state <= {state[14:0], ^(state & RT_LFSR_TAPS)};
        end
    end

endmodule
`endif

// File: rtl/rt_pixel_scan.sv
// Row-major pixel/sample sequencer feeding the ray generation unit.
// Sub-pixel jitter is enabled by defining RT_PIXEL_SCAN_JITTER_EN.
module rt_pixel_scan
    import rt_pkg::*;
#(
    parameter int unsigned DIM_W = RT_DIM_W,
    parameter int unsigned SPP_W = RT_SPP_W,
    parameter int unsigned IW    = 16,
    parameter int unsigned QW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DIM_W-1:0] img_w,
    input  logic [DIM_W-1:0] img_h,
    input  logic [SPP_W-1:0] spp,
    input  logic             ready,
    output logic             valid,
    sfp_if.out               x,
    sfp_if.out               y,
    output logic             last_row,
    output logic             last_frame,
    output logic             busy,
    output logic             done
);

    rt_scan_state_e   state_q, state_d;
    logic [DIM_W-1:0] cx_q, cx_d, cy_q, cy_d, w_q, w_d, h_q, h_d;
    logic [SPP_W-1:0] cs_q, cs_d, spp_q, spp_d;
    logic             done_q, done_d;
    logic             cs_wrap, cx_wrap, cy_wrap;

    assign cs_wrap = (cs_q == spp_q - SPP_W'(1));
    assign cx_wrap = (cx_q == w_q - DIM_W'(1));
    assign cy_wrap = (cy_q == h_q - DIM_W'(1));

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        cs_d    = cs_q;
        w_d     = w_q;
        h_d     = h_q;
        spp_d   = spp_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cx_d    = '0;
            cy_d    = '0;
            cs_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (img_w != '0 && img_h != '0) begin
                            w_d     = img_w;
                            h_d     = img_h;
                            spp_d   = (spp == '0) ? SPP_W'(1) : spp;
                            cx_d    = '0;
                            cy_d    = '0;
                            cs_d    = '0;
                            state_d = RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (ready) begin
                        if (!cs_wrap) begin
                            cs_d = cs_q + SPP_W'(1);
                        end else begin
                            cs_d = '0;
                            if (!cx_wrap) begin
                                cx_d = cx_q + DIM_W'(1);
                            end else begin
                                cx_d = '0;
                                if (!cy_wrap) begin
                                    cy_d = cy_q + DIM_W'(1);
                                end else begin
                                    cy_d    = '0;
                                    state_d = IDLE;
                                    done_d  = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            cs_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            spp_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cs_q    <= cs_d;
            w_q     <= w_d;
            h_q     <= h_d;
            spp_q   <= spp_d;
            done_q  <= done_d;
        end
    end

    assign valid      = (state_q == RUN);
    assign busy       = valid;
    assign done       = done_q;
    assign last_row   = valid && cx_wrap && cs_wrap;
    assign last_frame = last_row && cy_wrap;

`ifdef RT_PIXEL_SCAN_JITTER_EN
    localparam logic [IW+QW-1:0] HALF = (IW+QW)'(1) << (QW - 1);

    logic [15:0]       lfsr;
    logic [QW-1:0]     x_frac, y_frac;
    logic [IW+QW-1:0]  offset;

    rt_lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (busy && ready && !abort),
        .state   (lfsr)
    );

    // Jitter only while a beat is presented so idle/reset coordinates read as zero.
    assign x_frac = busy ? lfsr[QW-1:0] : '0;
    assign y_frac = busy ? lfsr[15:16-QW] : '0;
    assign offset = busy ? HALF : '0;

    assign x.val = $signed({{(IW-DIM_W){1'b0}}, cx_q, x_frac} - offset);
    assign y.val = $signed({{(IW-DIM_W){1'b0}}, cy_q, y_frac} - offset);
`else
    assign x.val = $signed({{(IW-DIM_W){1'b0}}, cx_q, {QW{1'b0}}});
    assign y.val = $signed({{(IW-DIM_W){1'b0}}, cy_q, {QW{1'b0}}});
`endif

endmodule
